// File: rtl/narnet_pkg.sv
// Shared constants, wr_sel encoding and FSM state type for the NAR net loader.
// NARNET_LOADER_CHECKSUM_EN adds the LD_CHK state.
package narnet_pkg;
  localparam int N    = 5;
  localparam int TAPS = 16;
  localparam int DW   = 8;
  localparam int RW   = 3;
  localparam int CW   = 4;

  localparam int NUM_PARAMS = 2 * N + N * TAPS + 1;

  localparam logic [1:0] SEL_B1 = 2'd0;
  localparam logic [1:0] SEL_W1 = 2'd1;
  localparam logic [1:0] SEL_B2 = 2'd2;
  localparam logic [1:0] SEL_W2 = 2'd3;

  localparam logic [RW-1:0] ROW_LAST = RW'(N - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(TAPS - 1);

`ifdef NARNET_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE, LD_B1, LD_W1, LD_B2, LD_W2, LD_CHK, DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, LD_B1, LD_W1, LD_B2, LD_W2, DONE
  } state_t;
`endif
endpackage

// File: rtl/narnet_param_regs.sv
// Parameter register file of the NAR net, written through the loader's wr_* bus.
// Ports: i_clk, i_wr_en/sel/row/col/data in; o_b1, o_w1, o_b2, o_w2 out.
module narnet_param_regs
  import narnet_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_wr_en,
  input  logic [1:0]    i_wr_sel,
  input  logic [RW-1:0] i_wr_row,
  input  logic [CW-1:0] i_wr_col,
  input  logic [DW-1:0] i_wr_data,
  output logic [DW-1:0] o_b1 [N],
  output logic [DW-1:0] o_w1 [N][TAPS],
  output logic [DW-1:0] o_b2,
  output logic [DW-1:0] o_w2 [N]
);
  // No reset: a reloaded network keeps old values until overwritten.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      unique case (i_wr_sel)
        SEL_B1: o_b1[i_wr_row] <= i_wr_data;
        SEL_W1: o_w1[i_wr_row][i_wr_col] <= i_wr_data;
        SEL_B2: o_b2 <= i_wr_data;
        SEL_W2: o_w2[i_wr_row] <= i_wr_data;
      endcase
    end
  end
endmodule

// File: rtl/narnet_weight_loader.sv
// Streams bytes (b1, w1 row-major, b2, w2) into NAR net parameter registers.
// Ports: i_clk, i_rst (sync, active-low), i_start, i_s_valid/o_s_ready/i_s_data
// stream in; o_wr_en/sel/row/col/data write bus; o_busy, o_done, o_err status.
// NARNET_LOADER_CHECKSUM_EN: trailing XOR checksum byte drives o_err.
module narnet_weight_loader
  import narnet_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic          i_s_valid,
  output logic          o_s_ready,
  input  logic [DW-1:0] i_s_data,
  output logic          o_wr_en,
  output logic [1:0]    o_wr_sel,
  output logic [RW-1:0] o_wr_row,
  output logic [CW-1:0] o_wr_col,
  output logic [DW-1:0] o_wr_data,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err
);
  state_t        r_state;
  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic          r_ready;
  logic          r_busy;
  logic          r_done;
  logic          r_wr_en;
  logic [1:0]    r_wr_sel;
  logic [RW-1:0] r_wr_row;
  logic [CW-1:0] r_wr_col;
  logic [DW-1:0] r_wr_data;
  logic          w_acc;
  logic          w_param;
  logic [1:0]    w_sel;

  assign w_acc = i_s_valid && r_ready;

`ifdef NARNET_LOADER_CHECKSUM_EN
  logic [DW-1:0] r_xor;
  logic          r_err;
  // The checksum byte is consumed but never written.
  assign w_param = w_acc && (r_state != LD_CHK);
  assign o_err   = r_err;
`else
  assign w_param = w_acc;
  assign o_err   = 1'b0;
`endif

  always_comb begin
    w_sel = SEL_B1;
    unique case (r_state)
      LD_W1:   w_sel = SEL_W1;
      LD_B2:   w_sel = SEL_B2;
      LD_W2:   w_sel = SEL_W2;
      default: w_sel = SEL_B1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state   <= IDLE;
      r_row     <= '0;
      r_col     <= '0;
      r_ready   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_sel  <= '0;
      r_wr_row  <= '0;
      r_wr_col  <= '0;
      r_wr_data <= '0;
`ifdef NARNET_LOADER_CHECKSUM_EN
      r_xor     <= '0;
      r_err     <= 1'b0;
`endif
    end else begin
      r_wr_en <= 1'b0;
      // Counters sit at 0 outside their stage, so row/col are always valid.
      if (w_param) begin
        r_wr_en   <= 1'b1;
        r_wr_sel  <= w_sel;
        r_wr_row  <= r_row;
        r_wr_col  <= r_col;
        r_wr_data <= i_s_data;
`ifdef NARNET_LOADER_CHECKSUM_EN
        r_xor     <= r_xor ^ i_s_data;
`endif
      end
      unique case (r_state)
        IDLE, DONE: begin
          if (i_start) begin
            r_state <= LD_B1;
            r_ready <= 1'b1;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_row   <= '0;
            r_col   <= '0;
`ifdef NARNET_LOADER_CHECKSUM_EN
            r_xor   <= '0;
            r_err   <= 1'b0;
`endif
          end
        end
        LD_B1: begin
          if (w_acc) begin
            if (r_row == ROW_LAST) begin
              r_row   <= '0;
              r_state <= LD_W1;
            end else begin
              r_row <= r_row + 1'b1;
            end
          end
        end
        LD_W1: begin
          if (w_acc) begin
            if (r_col == COL_LAST) begin
              r_col <= '0;
              if (r_row == ROW_LAST) begin
                r_row   <= '0;
                r_state <= LD_B2;
              end else begin
                r_row <= r_row + 1'b1;
              end
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
        end
        LD_B2: begin
          if (w_acc) r_state <= LD_W2;
        end
        LD_W2: begin
          if (w_acc) begin
            if (r_row == ROW_LAST) begin
              r_row <= '0;
`ifdef NARNET_LOADER_CHECKSUM_EN
              r_state <= LD_CHK;
`else
              r_state <= DONE;
              r_ready <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
`endif
            end else begin
              r_row <= r_row + 1'b1;
            end
          end
        end
`ifdef NARNET_LOADER_CHECKSUM_EN
        LD_CHK: begin
          if (w_acc) begin
            r_err   <= (i_s_data != r_xor);
            r_state <= DONE;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
`endif
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_s_ready = r_ready;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_wr_en   = r_wr_en;
  assign o_wr_sel  = r_wr_sel;
  assign o_wr_row  = r_wr_row;
  assign o_wr_col  = r_wr_col;
  assign o_wr_data = r_wr_data;
endmodule

// File: tb/tb_narnet_weight_loader.sv
// Randomized self-checking bench for narnet_weight_loader.
// Write bus is scoreboarded against a stream-order model; regs file read back.
module tb_narnet_weight_loader;
  import narnet_pkg::*;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready;
  logic          wr_en;
  logic [1:0]    wr_sel;
  logic [RW-1:0] wr_row;
  logic [CW-1:0] wr_col;
  logic [DW-1:0] wr_data;
  logic          busy;
  logic          done;
  logic          err;
  logic [DW-1:0] b1 [N];
  logic [DW-1:0] w1 [N][TAPS];
  logic [DW-1:0] b2;
  logic [DW-1:0] w2 [N];

  int n_checks = 0;
  int n_errors = 0;
  logic [16:0] got_q[$];
  logic [7:0]  stim [NUM_PARAMS];

  always #5 clk = ~clk;

  narnet_weight_loader u_dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_start   (start),
    .i_s_valid (s_valid),
    .o_s_ready (s_ready),
    .i_s_data  (s_data),
    .o_wr_en   (wr_en),
    .o_wr_sel  (wr_sel),
    .o_wr_row  (wr_row),
    .o_wr_col  (wr_col),
    .o_wr_data (wr_data),
    .o_busy    (busy),
    .o_done    (done),
    .o_err     (err)
  );

  narnet_param_regs u_regs (
    .i_clk     (clk),
    .i_wr_en   (wr_en),
    .i_wr_sel  (wr_sel),
    .i_wr_row  (wr_row),
    .i_wr_col  (wr_col),
    .i_wr_data (wr_data),
    .o_b1      (b1),
    .o_w1      (w1),
    .o_b2      (b2),
    .o_w2      (w2)
  );

  always @(negedge clk)
    if (wr_en) got_q.push_back({wr_sel, wr_row, wr_col, wr_data});

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Target of the k-th stream byte, from the stream order alone.
  function automatic logic [16:0] exp_entry(input int k, input logic [7:0] d);
    int m;
    if (k < N) return {2'd0, 3'(k), 4'd0, d};
    m = k - N;
    if (m < N * TAPS) return {2'd1, 3'(m / TAPS), 4'(m % TAPS), d};
    m = m - N * TAPS;
    if (m == 0) return {2'd2, 3'd0, 4'd0, d};
    return {2'd3, 3'(m - 1), 4'd0, d};
  endfunction

  function automatic logic [7:0] stim_xor();
    logic [7:0] x = '0;
    for (int k = 0; k < NUM_PARAMS; k++) x = x ^ stim[k];
    return x;
  endfunction

  function automatic logic [16:0] got_at(input int k);
    if (k < got_q.size()) return got_q[k];
    return '1;
  endfunction

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_pct);
    int t;
    t = 0;
    while (gap_pct > 0 && $urandom_range(99) < gap_pct && t < 8) begin
      s_valid = 1'b0;
      @(negedge clk);
      t++;
    end
    s_valid = 1'b1;
    s_data  = b;
    t = 0;
    while (!s_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!s_ready) check("ready_timeout", 32'(s_ready), 1);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic send_range(input int from, input int to, input int gap);
    for (int k = from; k <= to; k++) send_byte(stim[k], gap);
  endtask

  task automatic send_chk(input logic [7:0] b, input int gap);
`ifdef NARNET_LOADER_CHECKSUM_EN
    send_byte(b, gap);
`else
    if (b != b) send_byte(b, gap);
`endif
  endtask

  task automatic check_seq(input string tag);
    int n;
    check({tag, "_count"}, got_q.size(), NUM_PARAMS);
    n = (got_q.size() < NUM_PARAMS) ? got_q.size() : NUM_PARAMS;
    for (int k = 0; k < n; k++) check(tag, got_q[k], exp_entry(k, stim[k]));
  endtask

  task automatic check_end(input string tag);
    check({tag, "_done"}, 32'(done), 1);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_rdy"}, 32'(s_ready), 0);
  endtask

  initial begin
    int n0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(s_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_wr", {wr_en, wr_sel, wr_row, wr_col, wr_data}, 0);
    rst = 1'b1;
    @(negedge clk);

    // Full ramp load, s_valid held high.
    for (int k = 0; k < NUM_PARAMS; k++) stim[k] = 8'(k);
    got_q.delete();
    pulse_start();
    check("start_busy", 32'(busy), 1);
    check("start_rdy", 32'(s_ready), 1);
    send_range(0, NUM_PARAMS - 1, 0);
    send_chk(stim_xor(), 0);
    check_end("ramp");
    check("ramp_err", 32'(err), 0);
    repeat (2) @(negedge clk);
    check_seq("ramp_seq");
    check("byte5", got_at(5), {2'd1, 3'd0, 4'd0, 8'd5});
    check("byte84", got_at(84), {2'd1, 3'd4, 4'd15, 8'd84});
    check("byte85", got_at(85), {2'd2, 3'd0, 4'd0, 8'd85});
    check("byte90", got_at(90), {2'd3, 3'd4, 4'd0, 8'd90});
    check("reg_w1_4_15", w1[4][15], 84);
    check("reg_b2", b2, 85);
    check("reg_w2_4", w2[4], 90);

    // Bytes offered while idle in DONE must not be consumed.
    n0 = got_q.size();
    s_valid = 1'b1;
    s_data  = 8'h5A;
    repeat (3) @(negedge clk);
    s_valid = 1'b0;
    check("done_no_write", got_q.size(), n0);
    check("done_hold", 32'(done), 1);

    // Extreme signed values first.
    for (int k = 0; k < NUM_PARAMS; k++) stim[k] = 8'($urandom);
    stim[0] = 8'h80;
    stim[1] = 8'h7F;
    stim[2] = 8'hFF;
    got_q.delete();
    pulse_start();
    check("restart_done", 32'(done), 0);
    send_range(0, NUM_PARAMS - 1, 0);
    send_chk(stim_xor(), 0);
    check_end("neg");
    repeat (2) @(negedge clk);
    check_seq("neg_seq");
    check("reg_b1_0", b1[0], 8'h80);
    check("reg_b1_1", b1[1], 8'h7F);
    check("reg_b1_2", b1[2], 8'hFF);

    // Random data with ~50% valid gaps.
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < NUM_PARAMS; k++) stim[k] = 8'($urandom);
      got_q.delete();
      pulse_start();
      send_range(0, NUM_PARAMS - 1, 50);
      send_chk(stim_xor(), 50);
      check_end("gap");
      repeat (2) @(negedge clk);
      check_seq("gap_seq");
    end

    // Reset in the middle of a load.
    for (int k = 0; k < NUM_PARAMS; k++) stim[k] = 8'(k + 7);
    pulse_start();
    send_range(0, 40, 0);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_done", 32'(done), 0);
    check("mid_rst_rdy", 32'(s_ready), 0);
    rst = 1'b1;
    @(negedge clk);
    got_q.delete();
    pulse_start();
    send_range(0, NUM_PARAMS - 1, 0);
    send_chk(stim_xor(), 0);
    check_end("reload");
    repeat (2) @(negedge clk);
    check("reload_first", got_at(0), exp_entry(0, stim[0]));
    check_seq("reload_seq");

    // start while busy is ignored.
    for (int k = 0; k < NUM_PARAMS; k++) stim[k] = 8'($urandom);
    got_q.delete();
    pulse_start();
    send_range(0, 9, 0);
    pulse_start();
    check("busy_start_busy", 32'(busy), 1);
    send_range(10, NUM_PARAMS - 1, 0);
    send_chk(stim_xor(), 0);
    check_end("busy_start");
    repeat (2) @(negedge clk);
    check("busy_start_b10", got_at(10), exp_entry(10, stim[10]));
    check_seq("busy_start_seq");

`ifdef NARNET_LOADER_CHECKSUM_EN
    for (int k = 0; k < NUM_PARAMS; k++) stim[k] = 8'h01;
    pulse_start();
    send_range(0, NUM_PARAMS - 1, 0);
    send_byte(8'h01, 0);
    check("chk_ok_err", 32'(err), 0);
    check("chk_ok_done", 32'(done), 1);
    pulse_start();
    check("chk_clr_done", 32'(done), 0);
    send_range(0, NUM_PARAMS - 1, 0);
    send_byte(8'h00, 0);
    check("chk_bad_err", 32'(err), 1);
    check("chk_bad_done", 32'(done), 1);
    pulse_start();
    check("chk_err_clr", 32'(err), 0);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
`else
    check("err_tied", 32'(err), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
